// File: rtl/pet_pkg.sv
// Shared definitions for the pet state engine: state encoding and mood evaluation.
// Latency: none (types and a pure function).
// Backpressure: none.
package pet_pkg;

  localparam int ST_W = 4;
  localparam int ST_N = 10;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_NEUTRAL = 4'd1,
    ST_TIRED   = 4'd2,
    ST_SLEEP   = 4'd3,
    ST_HUNGRY  = 4'd4,
    ST_SAD     = 4'd5,
    ST_PLAYING = 4'd6,
    ST_BORED   = 4'd7,
    ST_DEATH   = 4'd8,
    ST_TEST    = 4'd9
  } state_t;

  // Mood derived from the three need levels; first matching rule wins.
  function automatic state_t mood(input int e, input int h, input int f,
                                  input int lvl_max, input int low_th);
    int n_low;
    n_low = ((e <= low_th) ? 1 : 0) + ((h <= low_th) ? 1 : 0) + ((f <= low_th) ? 1 : 0);
    if (e == lvl_max && h == lvl_max && f == lvl_max) return ST_IDLE;
    else if (n_low >= 2)                               return ST_SAD;
    else if (e <= low_th)                              return ST_TIRED;
    else if (h <= low_th)                              return ST_HUNGRY;
    else if (f <= low_th)                              return ST_BORED;
    else                                               return ST_NEUTRAL;
  endfunction

endpackage

// File: rtl/pet_state_engine_need.sv
// One need level with private decay and gain tick counters, saturating at 0 and MAX.
// Latency: level updates at the edge where the completing tick or bump is sampled.
// Backpressure: none; freeze holds counters and level, load/clear override freeze.
module pet_need_counter #(
  parameter int W       = 3,
  parameter int MAX     = 5,
  parameter int DEC_PER = 8,
  parameter int INC_PER = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         gain_en,
  input  logic         freeze,
  input  logic         bump,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clear,
  output logic [W-1:0] level
);

  localparam int DW = (DEC_PER > 1) ? $clog2(DEC_PER) : 1;
  localparam int IW = (INC_PER > 1) ? $clog2(INC_PER) : 1;

  logic [DW-1:0] dec_cnt, dec_cnt_nxt;
  logic [IW-1:0] inc_cnt, inc_cnt_nxt, inc_base;
  logic          gain_q;
  logic          dec_hit, inc_hit, up, down;
  logic [W-1:0]  level_nxt;

  // Period counting: gain counter restarts from zero on the first cycle of the gain state,
  // decay is paused whenever the gain state is active.
  always_comb begin
    inc_base    = (gain_en && !gain_q) ? '0 : inc_cnt;
    inc_cnt_nxt = inc_base;
    dec_cnt_nxt = dec_cnt;
    inc_hit     = 1'b0;
    dec_hit     = 1'b0;
    if (gain_en) begin
      if (tick) begin
        if (inc_base == IW'(INC_PER - 1)) begin
          inc_hit     = 1'b1;
          inc_cnt_nxt = '0;
        end else begin
          inc_cnt_nxt = inc_base + 1'b1;
        end
      end
    end else if (tick) begin
      if (dec_cnt == DW'(DEC_PER - 1)) begin
        dec_hit     = 1'b1;
        dec_cnt_nxt = '0;
      end else begin
        dec_cnt_nxt = dec_cnt + 1'b1;
      end
    end
  end

  // Saturating level step; a simultaneous up and down cancel out.
  always_comb begin
    up        = bump || inc_hit;
    down      = dec_hit;
    level_nxt = level;
    if (up && !down && level != W'(MAX))    level_nxt = level + 1'b1;
    else if (down && !up && level != '0)    level_nxt = level - 1'b1;
  end

  // Level and counter registers with load/clear taking precedence over freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level   <= W'(MAX);
      dec_cnt <= '0;
      inc_cnt <= '0;
      gain_q  <= 1'b0;
    end else begin
      gain_q <= gain_en;
      if (clear) begin
        dec_cnt <= '0;
        inc_cnt <= '0;
      end else if (!freeze) begin
        dec_cnt <= dec_cnt_nxt;
        inc_cnt <= inc_cnt_nxt;
      end
      if (load)         level <= load_val;
      else if (!freeze) level <= level_nxt;
    end
  end

endmodule

// File: rtl/pet_state_engine.sv
// Pet state engine: tick prescaler, three need levels, test-mode entry and mood/state FSM.
// Latency: inputs affect state at the next edge; levels affect mood state one cycle later.
// Backpressure: none; button pulses are consumed in the cycle they arrive.
module pet_state_engine
  import pet_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int LVL_W      = 3,
  parameter int LVL_MAX    = 5,
  parameter int LOW_TH     = 2,
  parameter int ENER_PER   = 40000,
  parameter int FEED_PER   = 10000,
  parameter int FUN_PER    = 20000,
  parameter int SLEEP_GAIN = 5000,
  parameter int PLAY_GAIN  = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_sleep,
  input  logic             btn_awake,
  input  logic             btn_feed,
  input  logic             btn_play,
  input  logic             giro,
  input  logic             test_en,
  input  logic [3:0]       test_sel,
  input  logic             test_load,
  output logic [3:0]       state,
  output logic [9:0]       state_oh,
  output logic             state_chg,
  output logic [LVL_W-1:0] energy,
  output logic [LVL_W-1:0] hunger,
  output logic [LVL_W-1:0] fun,
  output logic             tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [LVL_W-1:0] L_MAX = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] L_M1  = LVL_W'(LVL_MAX - 1);
  localparam logic [LVL_W-1:0] L_LOW = LVL_W'(LOW_TH);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_fire;
  logic             test_en_q, test_rise;
  state_t           state_q, state_nxt, mood_st;
  logic             any_zero, freeze, need_load, cnt_clr;
  logic [LVL_W-1:0] e_ld, h_ld, f_ld;

  // Level updates land on the same edge that raises tick, so the counters use tick_fire.
  assign tick_fire = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign test_rise = test_en && !test_en_q;
  assign any_zero  = (energy == '0) || (hunger == '0) || (fun == '0);
  assign freeze    = (state_q == ST_DEATH) || (state_q == ST_TEST);
  assign mood_st   = mood(int'(energy), int'(hunger), int'(fun), LVL_MAX, LOW_TH);
  assign state     = state_q;
  assign state_oh  = 10'b1 << state_q;

  // Prescaler producing one tick every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= tick_fire;
      div_cnt <= tick_fire ? '0 : div_cnt + 1'b1;
    end
  end

  // Next-state selection in priority order, plus test preset loading.
  always_comb begin
    state_nxt = state_q;
    need_load = 1'b0;
    cnt_clr   = 1'b0;
    e_ld      = energy;
    h_ld      = hunger;
    f_ld      = fun;
    if (state_q == ST_DEATH) begin
      state_nxt = ST_DEATH;
    end else if (any_zero && state_q != ST_TEST) begin
      state_nxt = ST_DEATH;
    end else if (test_rise) begin
      state_nxt = ST_TEST;
    end else begin
      case (state_q)
        ST_TEST: begin
          if (test_load) begin
            cnt_clr = 1'b1;
            case (test_sel)
              4'd1: begin need_load = 1'b1; e_ld = L_MAX; h_ld = L_MAX; f_ld = L_MAX; state_nxt = ST_IDLE;    end
              4'd2: begin need_load = 1'b1; e_ld = L_M1;  h_ld = L_M1;  f_ld = L_M1;  state_nxt = ST_NEUTRAL; end
              4'd3: begin need_load = 1'b1; e_ld = L_LOW; h_ld = L_MAX; f_ld = L_MAX; state_nxt = ST_TIRED;   end
              4'd4: begin need_load = 1'b1; e_ld = L_LOW; h_ld = L_MAX; f_ld = L_MAX; state_nxt = ST_SLEEP;   end
              4'd5: begin need_load = 1'b1; e_ld = L_MAX; h_ld = L_LOW; f_ld = L_MAX; state_nxt = ST_HUNGRY;  end
              4'd6: begin need_load = 1'b1; e_ld = L_LOW; h_ld = L_LOW; f_ld = L_MAX; state_nxt = ST_SAD;     end
              4'd7: begin need_load = 1'b1; e_ld = L_MAX; h_ld = L_MAX; f_ld = L_LOW; state_nxt = ST_PLAYING; end
              4'd8: begin need_load = 1'b1; e_ld = L_MAX; h_ld = L_MAX; f_ld = L_LOW; state_nxt = ST_BORED;   end
              4'd9: begin need_load = 1'b1; e_ld = '0;    h_ld = '0;    f_ld = '0;    state_nxt = ST_DEATH;   end
              default: ;
            endcase
          end
        end
        ST_SLEEP: begin
          if (btn_awake || btn_feed || energy == L_MAX) state_nxt = mood_st;
        end
        ST_PLAYING: begin
          if (!giro || fun == L_MAX) state_nxt = mood_st;
        end
        default: begin
          if (btn_sleep && !btn_play && energy < L_MAX)
            state_nxt = ST_SLEEP;
          else if (btn_play && !btn_sleep && fun < L_MAX && state_q != ST_TIRED)
            state_nxt = ST_PLAYING;
          else
            state_nxt = mood_st;
        end
      endcase
    end
  end

  // State register, change pulse and test_en edge history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      state_chg <= 1'b0;
      test_en_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      state_chg <= (state_nxt != state_q);
      test_en_q <= test_en;
    end
  end

  pet_need_counter #(.W(LVL_W), .MAX(LVL_MAX), .DEC_PER(ENER_PER), .INC_PER(SLEEP_GAIN)) u_energy (
    .clk(clk), .rst(rst), .tick(tick_fire), .gain_en(state_q == ST_SLEEP), .freeze(freeze),
    .bump(1'b0), .load(need_load), .load_val(e_ld), .clear(cnt_clr), .level(energy)
  );

  pet_need_counter #(.W(LVL_W), .MAX(LVL_MAX), .DEC_PER(FEED_PER), .INC_PER(1)) u_hunger (
    .clk(clk), .rst(rst), .tick(tick_fire), .gain_en(1'b0), .freeze(freeze),
    .bump(btn_feed), .load(need_load), .load_val(h_ld), .clear(cnt_clr), .level(hunger)
  );

  pet_need_counter #(.W(LVL_W), .MAX(LVL_MAX), .DEC_PER(FUN_PER), .INC_PER(PLAY_GAIN)) u_fun (
    .clk(clk), .rst(rst), .tick(tick_fire), .gain_en(state_q == ST_PLAYING), .freeze(freeze),
    .bump(1'b0), .load(need_load), .load_val(f_ld), .clear(cnt_clr), .level(fun)
  );

endmodule

// File: tb/tb_pet_state_engine.sv
// Directed bench for pet_state_engine with a fast prescaler and short need periods.
// Edge counter e counts rising edges since the latest reset release; samples are taken 1 ns after each edge.
module tb_pet_state_engine;

  logic       clk, rst;
  logic       btn_sleep, btn_awake, btn_feed, btn_play, giro;
  logic       test_en, test_load;
  logic [3:0] test_sel;
  logic [3:0] state;
  logic [9:0] state_oh;
  logic       state_chg, tick;
  logic [2:0] energy, hunger, fun;

  int checks = 0;
  int errors = 0;
  int e = 0;

  pet_state_engine #(
    .TICK_DIV(4), .LVL_W(3), .LVL_MAX(5), .LOW_TH(2),
    .ENER_PER(8), .FEED_PER(6), .FUN_PER(7), .SLEEP_GAIN(2), .PLAY_GAIN(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_sleep(btn_sleep), .btn_awake(btn_awake), .btn_feed(btn_feed), .btn_play(btn_play),
    .giro(giro), .test_en(test_en), .test_sel(test_sel), .test_load(test_load),
    .state(state), .state_oh(state_oh), .state_chg(state_chg),
    .energy(energy), .hunger(hunger), .fun(fun), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic run_to(input int t);
    step(t - e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_oh"}, 32'(state_oh), 1);
    chk({tag, "_energy"}, 32'(energy), 5);
    chk({tag, "_hunger"}, 32'(hunger), 5);
    chk({tag, "_fun"}, 32'(fun), 5);
    chk({tag, "_chg"}, 32'(state_chg), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
  endtask

  initial begin
    rst = 1'b0; btn_sleep = 1'b0; btn_awake = 1'b0; btn_feed = 1'b0; btn_play = 1'b0;
    giro = 1'b0; test_en = 1'b0; test_load = 1'b0; test_sel = 4'd0;
    step(2);
    chk_reset("rst0");

    // Free run from reset: hunger 6 ticks, fun 7 ticks, energy 8 ticks, tick every 4 edges.
    rst = 1'b1; e = 0;
    run_to(23);  chk("a23_state", 32'(state), 0); chk("a23_tick", 32'(tick), 0); chk("a23_hunger", 32'(hunger), 5);
    run_to(24);  chk("a24_hunger", 32'(hunger), 4); chk("a24_state", 32'(state), 0); chk("a24_tick", 32'(tick), 1);
    run_to(25);  chk("a25_state", 32'(state), 1); chk("a25_chg", 32'(state_chg), 1);
    run_to(26);  chk("a26_chg", 32'(state_chg), 0);
    run_to(72);  chk("a72_hunger", 32'(hunger), 2); chk("a72_state", 32'(state), 1);
    run_to(73);  chk("a73_hungry", 32'(state), 4);
    run_to(84);  chk("a84_fun", 32'(fun), 2); chk("a84_state", 32'(state), 4);
    run_to(85);  chk("a85_sad", 32'(state), 5);
    run_to(120); chk("a120_hunger", 32'(hunger), 0); chk("a120_energy", 32'(energy), 2);
                 chk("a120_fun", 32'(fun), 1); chk("a120_state", 32'(state), 5);
    run_to(121); chk("a121_death", 32'(state), 8); chk("a121_oh", 32'(state_oh), 32'h100);
    btn_sleep = 1'b1; step(1); btn_sleep = 1'b0;
    chk("a_death_sleep", 32'(state), 8);
    btn_feed = 1'b1; step(1); btn_feed = 1'b0;
    chk("a_death_feed", 32'(hunger), 0);
    run_to(160); chk("a160_energy", 32'(energy), 2); chk("a160_fun", 32'(fun), 1);
    test_en = 1'b1; step(1);
    chk("a_death_test", 32'(state), 8);
    rst = 1'b0; step(1);
    chk_reset("rst_death");
    test_en = 1'b0; step(1);

    // Test mode and presets.
    rst = 1'b1; e = 0;
    step(1);
    btn_feed = 1'b1; step(1); btn_feed = 1'b0;
    chk("b2_feed_sat", 32'(hunger), 5);
    run_to(20);  chk("b20_state", 32'(state), 0); chk("b20_tick", 32'(tick), 1);
    test_en = 1'b1; step(1);
    chk("b21_test", 32'(state), 9); chk("b21_chg", 32'(state_chg), 1); chk("b21_oh", 32'(state_oh), 32'h200);
    test_sel = 4'd6; test_load = 1'b1; step(1); test_load = 1'b0;
    chk("b22_sad", 32'(state), 5); chk("b22_energy", 32'(energy), 2);
    chk("b22_hunger", 32'(hunger), 2); chk("b22_fun", 32'(fun), 5);
    run_to(24);  chk("b24_hunger_clr", 32'(hunger), 2); chk("b24_hold_en", 32'(state), 5);
    test_en = 1'b0; step(1);
    test_en = 1'b1; step(1);
    chk("b26_test", 32'(state), 9);
    test_sel = 4'd12; test_load = 1'b1; step(1); test_load = 1'b0;
    chk("b27_sel12_state", 32'(state), 9); chk("b27_sel12_energy", 32'(energy), 2);
    chk("b27_sel12_hunger", 32'(hunger), 2); chk("b27_sel12_fun", 32'(fun), 5);
    test_sel = 4'd3; test_load = 1'b1; step(1); test_load = 1'b0;
    chk("b28_tired", 32'(state), 2); chk("b28_energy", 32'(energy), 2); chk("b28_hunger", 32'(hunger), 5);
    giro = 1'b1; btn_play = 1'b1; step(1); btn_play = 1'b0; giro = 1'b0;
    chk("b29_tired_play", 32'(state), 2);
    test_en = 1'b0; step(1);
    test_en = 1'b1; step(1);
    chk("b31_test", 32'(state), 9);
    test_sel = 4'd9; test_load = 1'b1; step(1); test_load = 1'b0;
    chk("b32_death", 32'(state), 8); chk("b32_energy", 32'(energy), 0);
    chk("b32_hunger", 32'(hunger), 0); chk("b32_fun", 32'(fun), 0);
    test_en = 1'b0; step(1);
    test_en = 1'b1; step(1);
    chk("b34_death_sticky", 32'(state), 8);

    // Sleep, feed and play from a free run.
    rst = 1'b0; test_en = 1'b0; step(1);
    rst = 1'b1; e = 0;
    run_to(66);  chk("c66_state", 32'(state), 1); chk("c66_energy", 32'(energy), 3);
                 chk("c66_hunger", 32'(hunger), 3); chk("c66_fun", 32'(fun), 3);
    btn_sleep = 1'b1; step(1); btn_sleep = 1'b0;
    chk("c67_sleep", 32'(state), 3);
    run_to(71);  chk("c71_energy", 32'(energy), 3);
    run_to(72);  chk("c72_energy", 32'(energy), 4); chk("c72_hunger", 32'(hunger), 2); chk("c72_state", 32'(state), 3);
    run_to(79);  chk("c79_energy", 32'(energy), 4);
    run_to(80);  chk("c80_energy", 32'(energy), 5); chk("c80_state", 32'(state), 3);
    run_to(81);  chk("c81_wake_hungry", 32'(state), 4);
    btn_feed = 1'b1; step(1); btn_feed = 1'b0;
    chk("c82_feed", 32'(hunger), 3);
    run_to(83);  chk("c83_neutral", 32'(state), 1);
    run_to(85);  chk("c85_bored", 32'(state), 7); chk("c85_fun", 32'(fun), 2);
    giro = 1'b1; btn_play = 1'b1; step(1); btn_play = 1'b0;
    chk("c86_playing", 32'(state), 6);
    run_to(92);  chk("c92_fun", 32'(fun), 3);
    run_to(95);  chk("c95_hunger", 32'(hunger), 3);
    btn_feed = 1'b1; step(1); btn_feed = 1'b0;
    chk("c96_feed_decay", 32'(hunger), 3); chk("c96_fun", 32'(fun), 3);
    run_to(100); chk("c100_fun", 32'(fun), 4); chk("c100_state", 32'(state), 6);
    giro = 1'b0; step(1);
    chk("c101_neutral", 32'(state), 1);
    test_en = 1'b1; step(1);
    chk("c102_test", 32'(state), 9);
    rst = 1'b0; step(1);
    chk_reset("rst_test");
    rst = 1'b1; test_en = 1'b0; step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
